scan_chain_tail_checker: RTL and testbench
==========================================

// Module: scan_chain_tail_checker
// PURPOSE
//  Downstream consumer of scan_chain_freq_test: samples SC_TAIL_pad from the FPGA-under-test's scan chain,
//  regenerates the PRBS7 stream driven on SC_HEAD_pad and compares bit-by-bit after the chain flush latency.
//  Reports error count, bits checked and first failing bit index for each frequency step of the sweep.
// PARAMETERS
//  CHAIN_LEN    1024   scan-chain length in flops; number of strobes discarded before checking
//  NUM_BITS     4096   PRBS bits compared per run (>=1)
//  SYNC_STAGES  2      synchronizer depth on SC_TAIL_pad (>=2)
//  PRBS_SEED    7'h7F  PRBS7 seed; must equal head-side seed; 0 is illegal and is replaced by 7'h7F
// PORTS
//  sys_clk        in   1   system clock; sole clock domain
//  sys_rst        in   1   synchronous, active-high reset
//  start          in   1   1-cycle pulse: begin a run (ignored unless IDLE or DONE)
//  abort          in   1   level/pulse: return to IDLE, done not raised
//  sample_stb     in   1   1-cycle pulse per CLK_pad period from generator; tail bit valid at sync output
//  SC_TAIL_pad    in   1   asynchronous scan-chain tail from the FPGA-under-test
//  busy           out  1   high in FLUSH or CHECK
//  done           out  1   1-cycle pulse when last bit compared
//  pass           out  1   valid from done until next start: err_count==0
//  err_count      out  16  mismatches, saturates at 16'hFFFF
//  bits_checked   out  32  compared bits in current/last run
//  first_err_idx  out  32  bits_checked value at first mismatch; 32'hFFFF_FFFF if none
// BEHAVIOUR
//  - Reset: busy=0, done=0, pass=0, err_count=0, bits_checked=0, first_err_idx=32'hFFFF_FFFF,
//    state=IDLE, LFSR=PRBS_SEED, flush counter=0, sync chain cleared to 0.
//  - SC_TAIL_pad passes through SYNC_STAGES flops; comparisons use only the last stage.
//  - Generator contract: sample_stb asserted >= SYNC_STAGES+1 sys_clk cycles after CLK_pad rising edge
//    and before next falling edge; block does not check this.
//  - PRBS7: x^7+x^6+1, output bit = lfsr[6], shift on each compared strobe only.
//  - FSM: IDLE -start-> FLUSH (clear counters, LFSR<=seed, first_err_idx<=all-ones, pass<=0).
//    FLUSH: count sample_stb; after CHAIN_LEN strobes -> CHECK (CHAIN_LEN=0: straight to CHECK).
//    CHECK: each sample_stb: mismatch = tail ^ lfsr[6]; bits_checked+1; err_count+mismatch (saturating);
//    first mismatch latches first_err_idx = bits_checked (pre-increment); advance LFSR.
//    Strobe that makes bits_checked==NUM_BITS -> DONE, done=1 that cycle+1 (registered), pass=(err_count'==0).
//    DONE: hold outputs; start -> FLUSH. DONE lasts until start/abort/reset; done pulse is single-cycle.
//  - abort in FLUSH/CHECK -> IDLE next cycle, counters hold last values, pass=0, no done pulse.
//  - start and abort same cycle: abort wins. start while busy: ignored.
//  - sample_stb without a run (IDLE/DONE): ignored, no counter change.
//  - sys_rst mid-run: full reset values next cycle, run discarded.
//  - Latency: sample_stb -> counters updated 1 cycle later; last strobe -> done 1 cycle later.
//  - Counters sized to NUM_BITS <= 2^32-1; flush counter width $clog2(CHAIN_LEN+1).
// STRUCTURE
//  - Package scan_test_pkg: PRBS7 polynomial taps, default seed constant, FSM state encoding
//    (IDLE, FLUSH, CHECK, DONE), ERR_SAT constant; shared with the head pattern generator.
//  - Sub-module prbs7_gen (sys_clk, sys_rst, load, seed, advance -> bit, state), same instance type
//    used by the head generator so both ends are bit-identical.
//  - Synchronizer, FSM, counters kept in this module.
// TESTING
//  - Ideal chain model (CHAIN_LEN=8 delay line fed by prbs7_gen), NUM_BITS=64 -> done after 72 strobes,
//    err_count=0, bits_checked=64, first_err_idx=32'hFFFFFFFF, pass=1.
//  - Inject single flip at compared bit 10 -> err_count=1, first_err_idx=10, pass=0.
//  - Tie SC_TAIL_pad=1 for NUM_BITS=70000 -> err_count=16'hFFFF saturated only if >65535 mismatches,
//    else exact count of PRBS zeros; pass=0, no wrap.
//  - abort at strobe 30 of CHECK -> IDLE next cycle, no done; new start -> clean run passes.
//  - start+abort same cycle in IDLE -> stays IDLE; start during CHECK -> ignored, run completes.
//  - sys_rst asserted mid-FLUSH -> all outputs reset values next cycle; PRBS_SEED=0 run passes vs 7'h7F head.

Source files
------------

// File: rtl/scan_test_pkg.sv
// scan_test_pkg
//   Constants and types shared by the scan-chain head pattern generator and
//   the tail checker so both ends agree on the PRBS7 stream and state names.
//   - PRBS7_TAPS         : feedback taps for x^7 + x^6 + 1 (lfsr[6] ^ lfsr[5])
//   - PRBS7_DEFAULT_SEED : seed used when an all-zero seed is requested
//   - ERR_SAT            : saturation value of the 16-bit error counter
//   - scan_state_e       : run state of the checker
package scan_test_pkg;

    localparam logic [6:0]  PRBS7_TAPS         = 7'b110_0000;
    localparam logic [6:0]  PRBS7_DEFAULT_SEED = 7'h7F;
    localparam logic [15:0] ERR_SAT            = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_CHECK,
        ST_DONE
    } scan_state_e;

    // An all-zero LFSR never leaves zero, so it is replaced by the default seed.
    function automatic logic [6:0] prbs7_legal_seed(input logic [6:0] seed);
        return (seed == '0) ? PRBS7_DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen
//   Fibonacci PRBS7 generator (x^7 + x^6 + 1), shared by the head generator
//   and the tail checker so both produce bit-identical streams.
//   Ports:
//     sys_clk, sys_rst : clock, synchronous active-high reset (LFSR <= RESET_SEED)
//     load, seed       : load seed (zero seed replaced by the default seed)
//     advance          : shift the LFSR by one bit (load has priority)
//     prbs_bit         : current output bit, lfsr[6]
//     state            : full LFSR contents
module prbs7_gen
    import scan_test_pkg::*;
#(
    parameter logic [6:0] RESET_SEED = PRBS7_DEFAULT_SEED
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       advance,
    output logic       prbs_bit,
    output logic [6:0] state
);

    logic [6:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = prbs7_legal_seed(seed);
        end else if (advance) begin
            lfsr_d = {lfsr_q[5:0], ^(lfsr_q & PRBS7_TAPS)};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lfsr_q <= prbs7_legal_seed(RESET_SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prbs_bit = lfsr_q[6];
    assign state    = lfsr_q;

endmodule

// File: rtl/scan_chain_tail_checker.sv
// scan_chain_tail_checker
//   Samples the scan-chain tail of the FPGA-under-test, discards CHAIN_LEN
//   flush strobes, then compares NUM_BITS tail bits against a locally
//   regenerated PRBS7 stream and reports the result of the run.
//   Ports:
//     sys_clk, sys_rst : clock, synchronous active-high reset
//     start, abort     : begin a run (from IDLE/DONE) / return to IDLE (wins over start)
//     sample_stb       : one pulse per chain clock; tail bit valid at synchronizer output
//     SC_TAIL_pad      : asynchronous scan-chain tail
//     busy, done, pass : run in progress / 1-cycle end pulse / run had no mismatches
//     err_count        : saturating mismatch count
//     bits_checked     : bits compared in the current/last run
//     first_err_idx    : bit index of the first mismatch, all-ones if none
module scan_chain_tail_checker
    import scan_test_pkg::*;
#(
    parameter int unsigned CHAIN_LEN   = 1024,
    parameter int unsigned NUM_BITS    = 4096,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  PRBS_SEED   = 7'h7F
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        abort,
    input  logic        sample_stb,
    input  logic        SC_TAIL_pad,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] bits_checked,
    output logic [31:0] first_err_idx
);

    localparam logic [6:0]         SEED       = prbs7_legal_seed(PRBS_SEED);
    localparam bit                 SKIP_FLUSH = (CHAIN_LEN == 0);
    localparam int unsigned        FLUSH_W    = SKIP_FLUSH ? 1 : $clog2(CHAIN_LEN + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(CHAIN_LEN - 1);
    localparam logic [31:0]        LAST_BIT   = 32'(NUM_BITS - 1);

    scan_state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [15:0]            err_q, err_d;
    logic [31:0]            bits_q, bits_d;
    logic [31:0]            first_q, first_d;
    logic                   pass_q, pass_d;
    logic                   done_q, done_d;

    logic       prbs_load, prbs_adv, prbs_bit;
    logic [6:0] prbs_state_unused;
    logic       mismatch;

    prbs7_gen #(
        .RESET_SEED(SEED)
    ) u_prbs (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (prbs_load),
        .seed    (SEED),
        .advance (prbs_adv),
        .prbs_bit(prbs_bit),
        .state   (prbs_state_unused)
    );

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], SC_TAIL_pad};
    assign mismatch = sync_q[SYNC_STAGES-1] ^ prbs_bit;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        bits_d      = bits_q;
        first_d     = first_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        prbs_load   = 1'b0;
        prbs_adv    = 1'b0;

        if (abort) begin
            // Counters keep their values so a host can inspect the aborted run.
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = SKIP_FLUSH ? ST_CHECK : ST_FLUSH;
                        flush_cnt_d = '0;
                        err_d       = '0;
                        bits_d      = '0;
                        first_d     = '1;
                        pass_d      = 1'b0;
                        prbs_load   = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (sample_stb) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_d     = ST_CHECK;
                            flush_cnt_d = '0;
                        end else begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (sample_stb) begin
                        prbs_adv = 1'b1;
                        bits_d   = bits_q + 32'd1;
                        if (mismatch) begin
                            // err_q still zero means this is the run's first mismatch.
                            if (err_q == '0) first_d = bits_q;
                            if (err_q != ERR_SAT) err_d = err_q + 16'd1;
                        end
                        if (bits_q == LAST_BIT) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            flush_cnt_q <= '0;
            err_q       <= '0;
            bits_q      <= '0;
            first_q     <= '1;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
            bits_q      <= bits_d;
            first_q     <= first_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    assign busy          = (state_q == ST_FLUSH) || (state_q == ST_CHECK);
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign bits_checked  = bits_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_scan_chain_tail_checker.sv
module tb_scan_chain_tail_checker;

    localparam int unsigned A_CL = 8;
    localparam int unsigned A_NB = 64;
    localparam int unsigned B_CL = 2;
    localparam int unsigned B_NB = 70000;
    localparam int unsigned C_NB = 20;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference PRBS7 sequence from its recurrence s[n+7] = s[n] ^ s[n+1],
    // seeded with 7'h7F (first seven output bits all ones).
    bit s_ref[127];

    function automatic bit ref_bit(input int unsigned k);
        return s_ref[k % 127];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- DUT A: ideal chain, CHAIN_LEN=8, NUM_BITS=64 ----------------
    logic a_rst, a_start_i, a_abort_i, a_stb, a_pad;
    logic a_busy, a_done, a_pass;
    logic [15:0] a_err;
    logic [31:0] a_bits, a_first;

    scan_chain_tail_checker #(
        .CHAIN_LEN(A_CL), .NUM_BITS(A_NB), .SYNC_STAGES(2), .PRBS_SEED(7'h7F)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(a_rst), .start(a_start_i), .abort(a_abort_i),
        .sample_stb(a_stb), .SC_TAIL_pad(a_pad), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_count(a_err), .bits_checked(a_bits), .first_err_idx(a_first)
    );

    // ---------------- DUT B: tail tied high, NUM_BITS=70000 ----------------
    logic b_rst, b_start_i, b_stb, b_pad;
    logic b_busy, b_done, b_pass;
    logic [15:0] b_err;
    logic [31:0] b_bits, b_first;

    scan_chain_tail_checker #(
        .CHAIN_LEN(B_CL), .NUM_BITS(B_NB), .SYNC_STAGES(2), .PRBS_SEED(7'h7F)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(b_rst), .start(b_start_i), .abort(1'b0),
        .sample_stb(b_stb), .SC_TAIL_pad(b_pad), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_count(b_err), .bits_checked(b_bits), .first_err_idx(b_first)
    );

    // ---------------- DUT C: zero seed, no flush, 3 sync stages ----------------
    logic c_rst, c_start_i, c_stb, c_pad;
    logic c_busy, c_done, c_pass;
    logic [15:0] c_err;
    logic [31:0] c_bits, c_first;

    scan_chain_tail_checker #(
        .CHAIN_LEN(0), .NUM_BITS(C_NB), .SYNC_STAGES(3), .PRBS_SEED(7'h00)
    ) dut_c (
        .sys_clk(sys_clk), .sys_rst(c_rst), .start(c_start_i), .abort(1'b0),
        .sample_stb(c_stb), .SC_TAIL_pad(c_pad), .busy(c_busy), .done(c_done),
        .pass(c_pass), .err_count(c_err), .bits_checked(c_bits), .first_err_idx(c_first)
    );

    // ---------------- Expected state of DUT A ----------------
    logic        e_busy = 1'b0, e_done = 1'b0, e_pass = 1'b0;
    int          e_err = 0;
    int unsigned e_bits = 0;
    logic [31:0] e_first = '1;
    bit          a_running = 1'b0;
    int unsigned run_stb = 0;
    bit          chain[$];
    bit          cmp_en = 1'b0;

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("a_busy", 32'(a_busy), 32'(e_busy));
            chk("a_done", 32'(a_done), 32'(e_done));
            chk("a_pass", 32'(a_pass), 32'(e_pass));
            chk("a_err_count", 32'(a_err), 32'(e_err));
            chk("a_bits_checked", a_bits, e_bits);
            chk("a_first_err_idx", a_first, e_first);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic atick();
        tick();
        e_done = 1'b0;
    endtask

    task automatic a_start();
        a_start_i = 1'b1;
        atick();
        a_start_i = 1'b0;
        if (!a_running) begin
            a_running = 1'b1;
            run_stb   = 0;
            e_err     = 0;
            e_bits    = 0;
            e_first   = '1;
            e_pass    = 1'b0;
            e_busy    = 1'b1;
            chain.delete();
            repeat (A_CL) chain.push_back(1'b0);
        end
    endtask

    task automatic a_abort(input bit with_start);
        a_abort_i = 1'b1;
        a_start_i = with_start;
        atick();
        a_abort_i = 1'b0;
        a_start_i = 1'b0;
        a_running = 1'b0;
        e_busy    = 1'b0;
        e_pass    = 1'b0;
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        atick();
        a_rst     = 1'b0;
        a_running = 1'b0;
        e_busy    = 1'b0;
        e_pass    = 1'b0;
        e_err     = 0;
        e_bits    = 0;
        e_first   = '1;
    endtask

    // One chain clock: head bit enters the ideal delay line, tail bit leaves it.
    task automatic a_strobe(input int flip_k);
        bit t;
        int k;
        t = 1'b0;
        k = -1;
        if (a_running) begin
            t = chain.pop_front();
            chain.push_back(ref_bit(run_stb));
            k = int'(run_stb) - int'(A_CL);
            if (k >= 0 && k == flip_k) t = ~t;
        end
        a_pad = t;
        repeat (3) atick();
        a_stb = 1'b1;
        atick();
        a_stb = 1'b0;
        if (a_running) begin
            if (k >= 0) begin
                if (t != ref_bit(k)) begin
                    if (e_err == 0) e_first = 32'(k);
                    if (e_err < 65535) e_err++;
                end
                e_bits++;
                if (e_bits == A_NB) begin
                    e_done    = 1'b1;
                    e_pass    = (e_err == 0);
                    e_busy    = 1'b0;
                    a_running = 1'b0;
                end
            end
            run_stb++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned zeros;
        a_rst = 1'b1; a_start_i = 1'b0; a_abort_i = 1'b0; a_stb = 1'b0; a_pad = 1'b0;
        b_rst = 1'b1; b_start_i = 1'b0; b_stb = 1'b0; b_pad = 1'b0;
        c_rst = 1'b1; c_start_i = 1'b0; c_stb = 1'b0; c_pad = 1'b0;

        for (int n = 0; n < 7; n++) s_ref[n] = 1'b1;
        for (int n = 7; n < 127; n++) s_ref[n] = s_ref[n-7] ^ s_ref[n-6];

        // Hand-derived values that pin the reference sequence.
        zeros = 0;
        for (int n = 0; n < 127; n++) if (!s_ref[n]) zeros++;
        chk("model_zeros_per_period", zeros, 32'd63);
        chk("model_bit7", 32'(ref_bit(7)), 32'd0);
        chk("model_bit13", 32'(ref_bit(13)), 32'd1);
        chk("model_bit19", 32'(ref_bit(19)), 32'd1);
        chk("model_bit127_wraps", 32'(ref_bit(127)), 32'd1);

        fork
            begin : thread_b
                int unsigned b_zeros;
                tick();
                b_rst = 1'b0;
                b_pad = 1'b1;
                repeat (3) tick();
                b_start_i = 1'b1;
                tick();
                b_start_i = 1'b0;
                chk("b_busy_after_start", 32'(b_busy), 32'd1);
                b_stb = 1'b1;
                repeat (B_CL + B_NB - 1) tick();
                chk("b_done_early", 32'(b_done), 32'd0);
                chk("b_bits_before_last", b_bits, B_NB - 1);
                tick();
                b_stb = 1'b0;
                b_zeros = 0;
                for (int unsigned k = 0; k < B_NB; k++) if (!ref_bit(k)) b_zeros++;
                chk("b_done", 32'(b_done), 32'd1);
                chk("b_err_count_model", 32'(b_err), b_zeros);
                chk("b_err_count_literal", 32'(b_err), 32'd34726);
                chk("b_bits_checked", b_bits, 32'd70000);
                chk("b_first_err_idx", b_first, 32'd7);
                chk("b_pass", 32'(b_pass), 32'd0);
                chk("b_busy_end", 32'(b_busy), 32'd0);
                tick();
                chk("b_done_single_cycle", 32'(b_done), 32'd0);
            end
            begin : thread_a
                atick();
                a_rst = 1'b0;
                c_rst = 1'b0;
                cmp_en = 1'b1;
                chk("reset_first_err_idx", a_first, 32'hFFFF_FFFF);
                chk("reset_busy", 32'(a_busy), 32'd0);

                // Clean run through the ideal chain.
                a_start();
                repeat (A_CL + A_NB) a_strobe(-1);
                chk("run1_done", 32'(a_done), 32'd1);
                chk("run1_pass", 32'(a_pass), 32'd1);
                chk("run1_bits", a_bits, 32'd64);
                chk("run1_first", a_first, 32'hFFFF_FFFF);
                a_strobe(-1);   // strobe in DONE is ignored

                // Single flipped bit at compared index 10.
                a_start();
                repeat (A_CL + A_NB) a_strobe(10);
                chk("flip_err", 32'(a_err), 32'd1);
                chk("flip_first", a_first, 32'd10);
                chk("flip_pass", 32'(a_pass), 32'd0);

                // Abort after 30 compared bits.
                a_start();
                repeat (A_CL + 30) a_strobe(-1);
                a_abort(1'b0);
                chk("abort_busy", 32'(a_busy), 32'd0);
                chk("abort_bits_held", a_bits, 32'd30);
                repeat (3) atick();

                // start and abort together in IDLE: abort wins.
                a_abort(1'b1);
                chk("start_abort_idle", 32'(a_busy), 32'd0);
                a_strobe(-1);

                // Clean run after abort.
                a_start();
                repeat (A_CL + A_NB) a_strobe(-1);
                chk("rerun_pass", 32'(a_pass), 32'd1);

                // start during CHECK is ignored.
                a_start();
                repeat (A_CL + 20) a_strobe(-1);
                a_start();
                repeat (A_NB - 20) a_strobe(-1);
                chk("busy_start_run_bits", a_bits, 32'd64);
                chk("busy_start_run_pass", 32'(a_pass), 32'd1);

                // Reset in the middle of FLUSH.
                a_start();
                repeat (4) a_strobe(-1);
                a_reset();
                chk("rst_flush_busy", 32'(a_busy), 32'd0);
                chk("rst_flush_first", a_first, 32'hFFFF_FFFF);
                atick();

                // Zero seed is replaced by 7'h7F and matches a 7'h7F head stream.
                c_start_i = 1'b1;
                tick();
                c_start_i = 1'b0;
                chk("c_busy_after_start", 32'(c_busy), 32'd1);
                for (int unsigned k = 0; k < C_NB; k++) begin
                    c_pad = ref_bit(k);
                    repeat (4) tick();
                    c_stb = 1'b1;
                    tick();
                    c_stb = 1'b0;
                end
                chk("c_done", 32'(c_done), 32'd1);
                chk("c_pass", 32'(c_pass), 32'd1);
                chk("c_err", 32'(c_err), 32'd0);
                chk("c_bits", c_bits, 32'd20);
                chk("c_first", c_first, 32'hFFFF_FFFF);
                cmp_en = 1'b0;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
